// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer; FETCH_ALIGN_CHECK_EN enables odd-target fixup.
// Latency: reset release -> imem_req after 1 edge; imem_ack -> if_valid after 1 edge.
// Backpressure: if_ready low holds if_instr/if_pc and suppresses further fetches.
module pc_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DATA_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [15:0]       pc,
   input  logic [15:0]       next_pc,
   output logic              imem_req,
   output logic [15:0]       imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_instr,
   output logic [15:0]       if_pc,
   input  logic              redirect_valid,
   input  logic [15:0]       redirect_pc,
   output logic              fetch_misalign
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       pc_q, pc_d;
   logic [15:0]       flush_addr_q, flush_addr_d;
   logic [15:0]       if_pc_q, if_pc_d;
   logic [DATA_W-1:0] if_instr_q, if_instr_d;
   logic              if_valid_q, if_valid_d;
   logic              misalign_q, misalign_d;
   logic [15:0]       redirect_tgt;
   logic              redirect_odd;

`ifdef FETCH_ALIGN_CHECK_EN
   assign redirect_tgt = {redirect_pc[15:1], 1'b0};
   assign redirect_odd = redirect_pc[0];
`else
   assign redirect_tgt = redirect_pc;
   assign redirect_odd = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            if (imem_ack) begin
               state_d = redirect_valid ? REQ : VALID;
            end else if (redirect_valid) begin
               state_d = FLUSH;
            end
         end
         VALID: begin
            if (redirect_valid || if_ready) begin
               state_d = REQ;
            end
         end
         FLUSH: begin
            // The stale request is finished by its ack; a redirect alone only retargets pc.
            if (imem_ack) begin
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_q;
      case (state_q)
         REQ: begin
            imem_req  = 1'b1;
            imem_addr = pc_q;
         end
         FLUSH: begin
            imem_req  = 1'b1;
            imem_addr = flush_addr_q;
         end
         default: begin
            imem_req  = 1'b0;
            imem_addr = pc_q;
         end
      endcase
   end

   always_comb begin
      pc_d         = pc_q;
      flush_addr_d = flush_addr_q;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;
      if_valid_d   = if_valid_q;
      misalign_d   = redirect_valid & redirect_odd;

      if (state_q == REQ) begin
         // Remember the in-flight address so a flush keeps presenting it.
         flush_addr_d = pc_q;
         if (imem_ack && !redirect_valid) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            pc_d       = next_pc;
            if_valid_d = 1'b1;
         end
      end

      if ((state_q == VALID) && if_ready) begin
         if_valid_d = 1'b0;
      end

      if (redirect_valid) begin
         pc_d       = redirect_tgt;
         if_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         flush_addr_q <= RESET_PC;
         if_pc_q      <= 16'h0000;
         if_instr_q   <= '0;
         if_valid_q   <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         flush_addr_q <= flush_addr_d;
         if_pc_q      <= if_pc_d;
         if_instr_q   <= if_instr_d;
         if_valid_q   <= if_valid_d;
         misalign_q   <= misalign_d;
      end
   end

   assign pc             = pc_q;
   assign if_valid       = if_valid_q;
   assign if_instr       = if_instr_q;
   assign if_pc          = if_pc_q;
   assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model (request outstanding / word held / stale).
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pc, next_pc, imem_addr, if_pc, redirect_pc;
   logic [15:0] imem_rdata, if_instr;
   logic        imem_req, imem_ack, if_valid, if_ready, redirect_valid, fetch_misalign;

   always #5 clk = ~clk;

   // PC_Incrementor stand-in
   assign next_pc = pc + 16'd2;

   pc_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc             (pc),
      .next_pc        (next_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_misalign (fetch_misalign)
   );

`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [15:0] T6_PC  = 16'h0032;
   localparam logic        T6_MIS = 1'b1;
`else
   localparam logic [15:0] T6_PC  = 16'h0033;
   localparam logic        T6_MIS = 1'b0;
`endif

   int vectors     = 0;
   int miscompares = 0;

   // Model: started after first edge, word held for decode, request in flight to be discarded
   logic [15:0] m_pc, m_stale_addr, m_instr, m_ipc;
   bit          m_started, m_have, m_stale, m_mis;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_stale_addr = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
      m_started = 0; m_have = 0; m_stale = 0; m_mis = 0;
   endtask

   task automatic model_step();
      logic [15:0] tgt;
      bit          mis_n;
      tgt   = redirect_pc;
      mis_n = 0;
`ifdef FETCH_ALIGN_CHECK_EN
      tgt[0] = 1'b0;
      mis_n  = redirect_valid & redirect_pc[0];
`endif
      if (!m_started) begin
         m_started = 1;
         if (redirect_valid) m_pc = tgt;
      end else if (redirect_valid) begin
         if (!m_have) begin
            if (imem_ack) m_stale = 0;
            else if (!m_stale) begin
               m_stale      = 1;
               m_stale_addr = m_pc;
            end
         end
         m_have = 0;
         m_pc   = tgt;
      end else if (!m_have) begin
         if (imem_ack) begin
            if (m_stale) m_stale = 0;
            else begin
               m_have  = 1;
               m_instr = imem_rdata;
               m_ipc   = m_pc;
               m_pc    = m_pc + 16'd2;
            end
         end
      end else if (if_ready) begin
         m_have = 0;
      end
      m_mis = mis_n;
   endtask

   task automatic check_all();
      chk("pc", pc, m_pc);
      chk("imem_req", {15'b0, imem_req}, {15'b0, m_started && !m_have});
      if (m_started && !m_have)
         chk("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
      chk("if_valid", {15'b0, if_valid}, {15'b0, m_have});
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ipc);
      chk("fetch_misalign", {15'b0, fetch_misalign}, {15'b0, m_mis});
   endtask

   task automatic step();
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input logic ack, input logic rdy, input logic rv,
                        input logic [15:0] rpc, input logic [15:0] rdata);
      imem_ack = ack; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc; imem_rdata = rdata;
   endtask

   initial begin
      drive(0, 0, 0, 16'h0000, 16'h0000);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      chk("rst_pc", pc, 16'h0000);
      chk("rst_req", {15'b0, imem_req}, 16'h0000);
      chk("rst_valid", {15'b0, if_valid}, 16'h0000);
      rst_n = 1'b1;
      step();

      // 1: zero-wait fetches at 0,2,4,6
      for (int k = 0; k < 4; k++) begin
         chk("t1_addr", imem_addr, 16'(2 * k));
         drive(1, 1, 0, 16'h0000, 16'h1000 + 16'(k));
         step();
         chk("t1_if_pc", if_pc, 16'(2 * k));
         chk("t1_instr", if_instr, 16'h1000 + 16'(k));
         step();
      end
      chk("t1_pc", pc, 16'h0008);

      // 4: redirect while fetch of 0x0008 is pending, ack two cycles later
      drive(0, 1, 1, 16'h0100, 16'h0000);
      step();
      chk("t4_req", {15'b0, imem_req}, 16'h0001);
      chk("t4_stale_addr", imem_addr, 16'h0008);
      chk("t4_pc", pc, 16'h0100);
      drive(0, 1, 0, 16'h0000, 16'h0000);
      step();
      drive(1, 1, 0, 16'h0000, 16'hBEEF);
      step();
      chk("t4_new_addr", imem_addr, 16'h0100);
      chk("t4_dropped", {15'b0, if_valid}, 16'h0000);

      // 2: ack delayed three cycles
      drive(0, 1, 0, 16'h0000, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_req", {15'b0, imem_req}, 16'h0001);
         chk("t2_addr", imem_addr, 16'h0100);
      end
      drive(1, 0, 0, 16'h0000, 16'h5A5A);
      step();
      chk("t2_valid", {15'b0, if_valid}, 16'h0001);
      chk("t2_instr", if_instr, 16'h5A5A);

      // 3: decode stalls five cycles
      drive(0, 0, 0, 16'h0000, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_instr", if_instr, 16'h5A5A);
         chk("t3_if_pc", if_pc, 16'h0100);
         chk("t3_req", {15'b0, imem_req}, 16'h0000);
         chk("t3_pc", pc, 16'h0102);
      end
      drive(0, 1, 0, 16'h0000, 16'h0000);
      step();
      chk("t3_next_addr", imem_addr, 16'h0102);

      // 5: redirect with same-cycle ack, then wrap from 0xFFFE
      drive(1, 1, 1, 16'hFFFE, 16'h7777);
      step();
      chk("t5_addr", imem_addr, 16'hFFFE);
      chk("t5_dropped", {15'b0, if_valid}, 16'h0000);
      drive(1, 1, 0, 16'h0000, 16'h1234);
      step();
      chk("t5_if_pc", if_pc, 16'hFFFE);
      chk("t5_wrap_pc", pc, 16'h0000);
      step();
      chk("t5_wrap_addr", imem_addr, 16'h0000);
      chk("t5_misalign", {15'b0, fetch_misalign}, 16'h0000);

      // 6: odd redirect target
      drive(0, 1, 1, 16'h0033, 16'h0000);
      step();
      chk("t6_pc", pc, T6_PC);
      chk("t6_misalign", {15'b0, fetch_misalign}, {15'b0, T6_MIS});
      drive(0, 1, 0, 16'h0000, 16'h0000);
      step();
      chk("t6_pulse_end", {15'b0, fetch_misalign}, 16'h0000);
      drive(1, 1, 0, 16'h0000, 16'h0000);
      step();
      chk("t6_addr", imem_addr, T6_PC);

      // Randomized traffic with one mid-run reset
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] tgt;
         tgt = 16'($urandom);
         if ($urandom_range(0, 3) != 0) tgt[0] = 1'b0;
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), tgt, 16'($urandom));
         if (n == 1500) begin
            #2 rst_n = 1'b0;
            #1;
            chk("arst_req", {15'b0, imem_req}, 16'h0000);
            chk("arst_pc", pc, 16'h0000);
            chk("arst_valid", {15'b0, if_valid}, 16'h0000);
            model_reset();
            @(negedge clk);
            check_all();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
